// File: rtl/ttl_counter_n.sv
// ttl_counter_n: synchronous presettable modulo-N up/down counter with a storage
// register, modelled on the 74LS163 (synchronous clear/load, P/T enables,
// ripple-carry output) combined with the 74LS590 (capture register).
//
// Parameters:
//   WIDTH   counter and data width in bits (2..16)
//   MODULO  count modulus (2..2**WIDTH)
//
// Ports:
//   clk      rising-edge clock for all state
//   reset    synchronous active-high reset; clears q and q_st
//   n_clr    synchronous active-low clear of q
//   n_load   synchronous active-low parallel load of q from d
//   d        parallel load data
//   enp      count enable P
//   ent      count enable T; also gates tc
//   up       count direction, 1 = up, 0 = down
//   rclk_en  storage-register capture strobe
//   q        live count register
//   q_st     storage register (pre-edge copy of q when captured)
//   tc       combinational terminal count / ripple carry
module ttl_counter_n #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MODULO = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             n_clr,
  input  logic             n_load,
  input  logic [WIDTH-1:0] d,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  input  logic             rclk_en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_st,
  output logic             tc
);

  // MODULO may equal 2**WIDTH, so only MODULO-1 is guaranteed to fit in WIDTH bits.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] Zero   = '0;
  localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q_st_q, q_st_d;
  logic [WIDTH-1:0] q_next_up, q_next_dn;

  // Up wraps on >= rather than == so an out-of-range loaded value returns to 0.
  // Down only wraps at 0, so an out-of-range value simply decrements.
  always_comb begin
    q_next_up = (q_q >= MaxVal) ? Zero : (q_q + One);
    q_next_dn = (q_q == Zero)   ? MaxVal : (q_q - One);
  end

  always_comb begin
    q_d = q_q;
    if (!n_clr) begin
      q_d = Zero;
    end else if (!n_load) begin
      q_d = d;
    end else if (enp && ent) begin
      q_d = up ? q_next_up : q_next_dn;
    end
  end

  // Capture samples the pre-edge count, independent of clear/load/enables.
  always_comb begin
    q_st_d = q_st_q;
    if (rclk_en) begin
      q_st_d = q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= Zero;
      q_st_q <= Zero;
    end else begin
      q_q    <= q_d;
      q_st_q <= q_st_d;
    end
  end

  // Independent of enp so cascaded stages see the carry as soon as the lower
  // stage sits at its terminal value.
  always_comb begin
    tc = ent & (up ? (q_q == MaxVal) : (q_q == Zero));
  end

  assign q    = q_q;
  assign q_st = q_st_q;

endmodule

// File: tb/tb_ttl_counter_n.sv
module tb_ttl_counter_n;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Single MODULO=10 counter.
  logic       reset, n_clr, n_load, enp, ent, up, rclk_en;
  logic [3:0] d, q, q_st;
  logic       tc;

  ttl_counter_n #(.WIDTH(4), .MODULO(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .n_clr   (n_clr),
    .n_load  (n_load),
    .d       (d),
    .enp     (enp),
    .ent     (ent),
    .up      (up),
    .rclk_en (rclk_en),
    .q       (q),
    .q_st    (q_st),
    .tc      (tc)
  );

  // Two MODULO=16 stages cascaded tc -> ent.
  logic       c_reset, c_n_load;
  logic [3:0] c_lo_d, c_hi_d, c_lo_q, c_hi_q, c_lo_st, c_hi_st;
  logic       c_lo_tc, c_hi_tc;

  ttl_counter_n #(.WIDTH(4), .MODULO(16)) u_lo (
    .clk     (clk),
    .reset   (c_reset),
    .n_clr   (1'b1),
    .n_load  (c_n_load),
    .d       (c_lo_d),
    .enp     (1'b1),
    .ent     (1'b1),
    .up      (1'b1),
    .rclk_en (1'b0),
    .q       (c_lo_q),
    .q_st    (c_lo_st),
    .tc      (c_lo_tc)
  );

  ttl_counter_n #(.WIDTH(4), .MODULO(16)) u_hi (
    .clk     (clk),
    .reset   (c_reset),
    .n_clr   (1'b1),
    .n_load  (c_n_load),
    .d       (c_hi_d),
    .enp     (1'b1),
    .ent     (c_lo_tc),
    .up      (1'b1),
    .rclk_en (1'b0),
    .q       (c_hi_q),
    .q_st    (c_hi_st),
    .tc      (c_hi_tc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; n_clr = 1'b1; n_load = 1'b1; enp = 1'b0; ent = 1'b0;
    up = 1'b1; rclk_en = 1'b1; d = 4'd0;
    c_reset = 1'b1; c_n_load = 1'b1; c_lo_d = 4'h0; c_hi_d = 4'h0;
    tick();
    check_val("rst_q", q, 0);
    check_val("rst_q_st", q_st, 0);
    check_val("rst_tc_up", tc, 0);
    ent = 1'b1; up = 1'b0; #1;
    check_val("rst_tc_dn", tc, 1);

    // Count up 1..9,0 with tc only at 9.
    reset = 1'b0; up = 1'b1; enp = 1'b1; ent = 1'b1; rclk_en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_val("up_q", q, i % 10);
      check_val("up_tc", tc, (i % 10) == 9);
    end

    // Count down from 0 -> 9 -> 8, then ent=0 holds.
    up = 1'b0; #1;
    check_val("dn_tc0", tc, 1);
    tick();
    check_val("dn_q9", q, 9);
    check_val("dn_tc9", tc, 0);
    tick();
    check_val("dn_q8", q, 8);
    ent = 1'b0; tick();
    check_val("hold_q", q, 8);
    check_val("hold_tc", tc, 0);

    // Out-of-range load 13: up wraps to 0, down decrements to 12.
    ent = 1'b1; up = 1'b1; n_load = 1'b0; d = 4'd13; tick();
    check_val("ld13_q", q, 13);
    check_val("ld13_tc", tc, 0);
    n_load = 1'b1; tick();
    check_val("ld13_up", q, 0);
    n_load = 1'b0; tick();
    up = 1'b0; n_load = 1'b1; tick();
    check_val("ld13_dn", q, 12);

    // Clear beats load.
    n_clr = 1'b0; n_load = 1'b0; d = 4'd5; tick();
    check_val("clr_ld", q, 0);
    n_clr = 1'b1; enp = 1'b0; tick();
    check_val("ld5", q, 5);
    n_load = 1'b1; rclk_en = 1'b1; tick();
    check_val("cap5", q_st, 5);
    // Reset beats load and capture.
    reset = 1'b1; n_load = 1'b0; tick();
    check_val("rst_ld_q", q, 0);
    check_val("rst_ld_st", q_st, 0);
    check_val("rst_ld_tc", tc, 1);

    // Reset mid-count, first edge after release counts normally.
    n_load = 1'b1; rclk_en = 1'b0; up = 1'b1; enp = 1'b1; tick();
    check_val("rst_mid", q, 0);
    reset = 1'b0; tick();
    check_val("post_rst", q, 1);

    // Capture coincident with count stores the old value.
    n_load = 1'b0; d = 4'd7; tick();
    n_load = 1'b1; rclk_en = 1'b1; tick();
    check_val("cap_q8", q, 8);
    check_val("cap_st7", q_st, 7);
    rclk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("cap_hold_q", q, (9 + i) % 10);
      check_val("cap_hold_st", q_st, 7);
    end

    // Cascade: 0x0F -> 0x10, 0xFF -> 0x00.
    c_reset = 1'b0; c_n_load = 1'b0; c_hi_d = 4'h0; c_lo_d = 4'hF; tick();
    check_val("casc_0f", {c_hi_q, c_lo_q}, 8'h0F);
    check_val("casc_lo_tc", c_lo_tc, 1);
    c_n_load = 1'b1; tick();
    check_val("casc_10", {c_hi_q, c_lo_q}, 8'h10);
    c_n_load = 1'b0; c_hi_d = 4'hF; c_lo_d = 4'hF; tick();
    check_val("casc_ff", {c_hi_q, c_lo_q}, 8'hFF);
    check_val("casc_hi_tc", c_hi_tc, 1);
    c_n_load = 1'b1; tick();
    check_val("casc_00", {c_hi_q, c_lo_q}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttl_counter_n.md
TTL_COUNTER_N -- requirements
Module: ttl_counter_n

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning counter and data width in bits (legal range 2..16).
REQ-002 SHALL provide parameter MODULO, default 16, meaning count modulus (legal range 2..2**WIDTH).
REQ-003 SHALL provide port clk  input  1  meaning single rising-edge clock for all state.
REQ-004 SHALL provide port reset  input  1  meaning synchronous active-high reset.
REQ-005 SHALL provide port n_clr  input  1  meaning synchronous active-low clear of the count (74LS163 style).
REQ-006 SHALL provide port n_load  input  1  meaning synchronous active-low parallel load.
REQ-007 SHALL provide port d  input  WIDTH  meaning parallel load data.
REQ-008 SHALL provide port enp  input  1  meaning count enable P.
REQ-009 SHALL provide port ent  input  1  meaning count enable T, which also gates tc.
REQ-010 SHALL provide port up  input  1  meaning direction: 1 = up, 0 = down.
REQ-011 SHALL provide port rclk_en  input  1  meaning storage-register capture strobe (74LS590 style).
REQ-012 SHALL provide port q  output  WIDTH  meaning live count register.
REQ-013 SHALL provide port q_st  output  WIDTH  meaning storage-register output.
REQ-014 SHALL provide port tc  output  1  meaning combinational terminal-count / ripple-carry output.
REQ-015 SHALL note the decided clocking: one clock; reset is synchronous and active-high.

Function
REQ-016 SHALL give per-edge count-register priority: reset > !n_clr > !n_load > (enp & ent) count > hold.
REQ-017 SHALL make !n_clr set q to 0 regardless of n_load, enp, ent and up.
REQ-018 SHALL make !n_load set q to d verbatim, including values >= MODULO, regardless of enp and ent.
REQ-019 SHALL advance the count only when enp=1 and ent=1, by exactly one step per clock edge (latency one edge).
REQ-020 SHALL count up as follows: q >= MODULO-1 -> 0; otherwise q+1.
REQ-021 SHALL count down as follows: q == 0 -> MODULO-1; otherwise q-1 (an out-of-range loaded value therefore decrements normally).
REQ-022 SHALL drive tc = ent & (up ? (q == MODULO-1) : (q == 0)), purely combinationally from the current q, up and ent, independent of enp.
REQ-023 SHALL make a change of up take effect on the same edge it is sampled, with no extra pipeline stage.
REQ-024 SHALL, when rclk_en=1 on an edge, load q_st with the pre-edge value of q, so that a capture coincident with a count stores the old value.
REQ-025 SHALL update q_st independently of n_clr, n_load, enp and ent; q_st holds when rclk_en=0.
REQ-026 SHALL produce outputs whose widths are exactly WIDTH, and all arithmetic SHALL be performed modulo MODULO with no overflow beyond WIDTH bits.
REQ-027 SHALL allow cascading: the tc of stage N wired to ent of stage N+1 yields a synchronous WIDTH*N-bit counter with no added latency.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, set q=0 and q_st=0, overriding every other input including rclk_en; tc then equals ent & ~up.
REQ-029 SHALL, if reset is asserted mid-count or mid-load, discard the pending operation, and the first edge after reset deasserts SHALL operate normally.
REQ-030 SHALL leave the power-up value before the first reset undefined; verification SHALL apply reset before checking.

Verification
REQ-031 SHALL cover the following scenario: MODULO=10, up=1, enp=ent=1 from q=0 -> q sequence 1..9,0; tc=1 only while q=9.
REQ-032 SHALL cover the following scenario: MODULO=10, up=0 from q=0 -> q=9, then 8; tc=1 while q=0 and ent=1; with ent=0, tc=0 and q holds.
REQ-033 SHALL cover the following scenario: n_load=0, d=13, MODULO=10, then count up -> q=13, then 0; count down from 13 -> 12.
REQ-034 SHALL cover the following scenario: n_clr=0 and n_load=0 on the same edge with d=5 -> q=0; then reset=1 and n_load=0 -> q=0 and q_st=0.
REQ-035 SHALL cover the following scenario: q=7 counting up with rclk_en=1 -> after the edge q=8 and q_st=7; rclk_en=0 for 3 edges -> q_st stays 7.
REQ-036 SHALL cover the following scenario: two WIDTH=4, MODULO=16 instances cascaded via tc->ent from 0x0F -> next edge gives 0x10; from 0xFF -> 0x00.
